// File: rtl/stepper_pkg.sv
// Shared types, coil table and phase-advance helper for the stepper sequencer.
package stepper_pkg;

    typedef enum logic [1:0] {
        WAVE = 2'b00,
        FULL = 2'b01,
        HALF = 2'b10,
        RSVD = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FREE = 2'b01,
        MOVE = 2'b10
    } state_t;

    // Energised coils per phase index, bit order [A,B,C,D].
    localparam logic [3:0] PHASE_TABLE [8] = '{
        4'b1000, 4'b1100, 4'b0100, 4'b0110,
        4'b0010, 4'b0011, 4'b0001, 4'b1001
    };

    // Wave lives on even indices and full on odd ones. When the parity already
    // matches, jump two. Otherwise take a single snap step. Half and reserved
    // always move one. The 3-bit result wraps modulo 8.
    function automatic logic [2:0] next_phase(input logic [2:0] ph,
                                              input logic       cw,
                                              input mode_t      m);
        logic [2:0] delta;
        delta = 3'd1;
        if (m == WAVE && !ph[0]) delta = 3'd2;
        if (m == FULL &&  ph[0]) delta = 3'd2;
        return cw ? ph + delta : ph - delta;
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step-rate divider. It counts 0..step_div and ticks on the terminal count.
// The period is therefore step_div+1 clocks. A clear holds the count at zero.
module step_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [DIV_W-1:0] step_div,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    // The comparison uses >= so that lowering step_div below the running count
    // ends the current period at once. The count never runs on to wrap.
    assign tick = !clear && (count >= step_div);

    // Advance the count, or return it to zero on a tick or a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clear || tick)
            count <= '0;
        else
            count <= count + 1'b1;
    end

endmodule

// File: rtl/stepper_sequencer.sv
// Four-coil stepper phase sequencer. Supports wave, full and half stepping.
// Runs either free-running or for a counted number of steps.
module stepper_sequencer
    import stepper_pkg::*;
#(
    parameter int DIV_W      = 24,
    parameter int POS_W      = 16,
    parameter bit ACTIVE_LOW = 1
) (
    input  logic             sys_clk_pin,
    input  logic             rst,
    input  logic             en,
    input  logic             cw,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] step_div,
    input  logic             run,
    input  logic             move_req,
    input  logic [POS_W-1:0] move_steps,
    output logic             move_ack,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [3:0]       coils,
    output logic [2:0]       phase,
    output logic [POS_W-1:0] position
);

    state_t           state, state_d;
    logic [POS_W-1:0] remaining, rem_d;
    logic [2:0]       phase_d;
    logic [3:0]       energised;
    logic             tick, clear;
    logic             accept, abort, done_d, do_step;

    // The prescaler only runs while enabled and stepping. It restarts on every
    // accepted move, so the first tick lands step_div clocks after the ack.
    assign clear = !en || (state == IDLE) || (state == FREE && move_req);

    step_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk      (sys_clk_pin),
        .rst      (rst),
        .clear    (clear),
        .step_div (step_div),
        .tick     (tick)
    );

    assign busy  = (state == MOVE);
    assign coils = ACTIVE_LOW ? ~energised : energised;

    // Next-state, move bookkeeping and step decision. A drop of en always wins
    // over a coincident tick.
    always_comb begin
        state_d = state;
        rem_d   = remaining;
        accept  = 1'b0;
        abort   = 1'b0;
        done_d  = 1'b0;
        do_step = 1'b0;
        case (state)
            IDLE: begin
                if (en && move_req) begin
                    accept  = 1'b1;
                    rem_d   = move_steps;
                    state_d = MOVE;
                end else if (en && run) begin
                    state_d = FREE;
                end
            end
            FREE: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (move_req) begin
                    accept  = 1'b1;
                    rem_d   = move_steps;
                    state_d = MOVE;
                end else if (!run) begin
                    state_d = IDLE;
                end else if (tick) begin
                    do_step = 1'b1;
                end
            end
            MOVE: begin
                if (!en) begin
                    abort   = 1'b1;
                    rem_d   = '0;
                    state_d = IDLE;
                end else if (remaining == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (tick) begin
                    do_step = 1'b1;
                    rem_d   = remaining - 1'b1;
                    if (remaining == POS_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        phase_d = do_step ? next_phase(phase, cw, mode_t'(mode)) : phase;
    end

    // State, counters and registered outputs. The coil pattern is registered
    // from the next phase, so it changes in the same cycle as phase and done.
    always_ff @(posedge sys_clk_pin or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
            phase     <= '0;
            position  <= '0;
            energised <= '0;
            move_ack  <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_d;
            remaining <= rem_d;
            phase     <= phase_d;
            if (do_step)
                position <= cw ? position + 1'b1 : position - 1'b1;
            energised <= en ? PHASE_TABLE[phase_d] : 4'b0000;
            move_ack  <= accept;
            done      <= done_d;
            aborted   <= abort;
        end
    end

endmodule

// File: tb/tb_stepper_sequencer.sv
// Bench for stepper_sequencer. It covers reset, free-run, counted moves, the
// zero-length move, abort on enable loss, and mode snapping.
module tb_stepper_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, cw, run, move_req;
    logic [1:0]  mode;
    logic [23:0] step_div;
    logic [15:0] move_steps;
    logic        move_ack, busy, done, aborted;
    logic [3:0]  coils;
    logic [2:0]  phase;
    logic [15:0] position;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  ph;
        logic [15:0] pos;
        bit          last;
    } exp_t;
    exp_t sb[$];

    logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                            4'b0010, 4'b0011, 4'b0001, 4'b1001};

    always #5 clk = ~clk;

    stepper_sequencer #(.DIV_W(24), .POS_W(16), .ACTIVE_LOW(1)) dut (
        .sys_clk_pin (clk),
        .rst         (rst),
        .en          (en),
        .cw          (cw),
        .mode        (mode),
        .step_div    (step_div),
        .run         (run),
        .move_req    (move_req),
        .move_steps  (move_steps),
        .move_ack    (move_ack),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .coils       (coils),
        .phase       (phase),
        .position    (position)
    );

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b0; en = 1'b0; cw = 1'b1; run = 1'b0; move_req = 1'b0;
        mode = 2'b10; step_div = 24'd0; move_steps = 16'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Wait at negedges until phase or position moves, or the budget expires.
    task automatic wait_step(input int budget, output bit got, output int cycles);
        logic [2:0]  p0;
        logic [15:0] q0;
        p0 = phase; q0 = position; got = 1'b0; cycles = 0;
        while (!got && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (phase !== p0 || position !== q0) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; cw = 1'b1; run = 1'b0; move_req = 1'b0;
        mode = 2'b10; step_div = 24'd0; move_steps = 16'd0;
        repeat (2) @(negedge clk);
        total++; if (coils !== 4'b1111) begin bad++; $display("FAIL reset_coils got=%b want=1111", coils); end
        total++; if (phase !== 3'd0) begin bad++; $display("FAIL reset_phase got=%0d want=0", phase); end
        total++; if (position !== 16'd0) begin bad++; $display("FAIL reset_position got=%0d want=0", position); end
        total++; if ({busy, done, aborted, move_ack} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b want=0000", {busy, done, aborted, move_ack});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_half_free();
        bit got; int cyc;
        for (int i = 1; i <= 9; i++) sb.push_back('{ph: 3'(i % 8), pos: 16'(i), last: 1'b0});
        mode = 2'b10; cw = 1'b1; step_div = 24'd3; en = 1'b1; run = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            exp_t e;
            e = sb.pop_front();
            wait_step(20, got, cyc);
            total++;
            if (!got) begin bad++; $display("FAIL half_timeout step=%0d", i); end
            else begin
                if (phase !== e.ph || position !== e.pos) begin
                    bad++; $display("FAIL half_step%0d got ph=%0d pos=%0d want ph=%0d pos=%0d", i, phase, position, e.ph, e.pos);
                end
                total++;
                if (coils !== ~tbl[e.ph]) begin bad++; $display("FAIL half_coils%0d got=%b want=%b", i, coils, ~tbl[e.ph]); end
                if (i > 1) begin
                    total++;
                    if (cyc != 4) begin bad++; $display("FAIL half_period%0d got=%0d want=4", i, cyc); end
                end
            end
        end
        run = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if (phase !== 3'd1 || position !== 16'd9) begin
            bad++; $display("FAIL half_stop got ph=%0d pos=%0d want ph=1 pos=9", phase, position);
        end
    endtask

    task automatic test_full_move();
        bit got; int cyc;
        do_reset();
        sb.push_back('{ph: 3'd7, pos: 16'hFFFF, last: 1'b0});
        sb.push_back('{ph: 3'd5, pos: 16'hFFFE, last: 1'b0});
        sb.push_back('{ph: 3'd3, pos: 16'hFFFD, last: 1'b1});
        en = 1'b1; mode = 2'b01; cw = 1'b0; step_div = 24'd2; move_steps = 16'd3; move_req = 1'b1;
        @(negedge clk);
        move_req = 1'b0;
        total++;
        if (move_ack !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL full_ack got ack=%b busy=%b want 1 1", move_ack, busy);
        end
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            wait_step(20, got, cyc);
            total++;
            if (!got) begin bad++; $display("FAIL full_timeout want ph=%0d", e.ph); end
            else if (phase !== e.ph || position !== e.pos || done !== e.last || busy !== !e.last) begin
                bad++; $display("FAIL full_step got ph=%0d pos=%h done=%b busy=%b want ph=%0d pos=%h done=%b",
                                phase, position, done, busy, e.ph, e.pos, e.last);
            end
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL full_done_width got=%b want=0", done); end
    endtask

    task automatic test_zero_move();
        move_steps = 16'd0; move_req = 1'b1;
        @(negedge clk);
        move_req = 1'b0;
        total++;
        if (move_ack !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL zero_ack got ack=%b done=%b want 1 0", move_ack, done);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || move_ack !== 1'b0 || busy !== 1'b0 || phase !== 3'd3) begin
            bad++; $display("FAIL zero_done got done=%b ack=%b busy=%b ph=%0d want 1 0 0 3", done, move_ack, busy, phase);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL zero_done_width got=%b want=0", done); end
    endtask

    task automatic test_abort();
        bit got; int cyc; bit seen;
        do_reset();
        for (int i = 1; i <= 4; i++) sb.push_back('{ph: 3'(i), pos: 16'(i), last: 1'b0});
        en = 1'b1; mode = 2'b10; cw = 1'b1; step_div = 24'd1; move_steps = 16'd10; move_req = 1'b1;
        @(negedge clk);
        move_req = 1'b0;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            wait_step(20, got, cyc);
            total++;
            if (!got) begin bad++; $display("FAIL abort_timeout want ph=%0d", e.ph); end
            else if (phase !== e.ph || position !== e.pos || done !== 1'b0) begin
                bad++; $display("FAIL abort_step got ph=%0d pos=%0d done=%b want ph=%0d pos=%0d", phase, position, done, e.ph, e.pos);
            end
        end
        en = 1'b0;
        @(negedge clk);
        total++;
        if (aborted !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || position !== 16'd4 || phase !== 3'd4 || coils !== 4'b1111) begin
            bad++; $display("FAIL abort_pulse got ab=%b done=%b busy=%b pos=%0d ph=%0d coils=%b want 1 0 0 4 4 1111",
                            aborted, done, busy, position, phase, coils);
        end
        @(negedge clk);
        total++;
        if (aborted !== 1'b0) begin bad++; $display("FAIL abort_width got=%b want=0", aborted); end
        move_steps = 16'd0; move_req = 1'b1; seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (move_ack !== 1'b0 || busy !== 1'b0 || position !== 16'd4) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL abort_req_ignored got activity=1 want=0"); end
        en = 1'b1;
        @(negedge clk);
        move_req = 1'b0;
        total++;
        if (move_ack !== 1'b1) begin bad++; $display("FAIL abort_reenable_ack got=%b want=1", move_ack); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode_switch();
        bit got; int cyc;
        do_reset();
        en = 1'b1; mode = 2'b10; cw = 1'b1; step_div = 24'd0; move_steps = 16'd3; move_req = 1'b1;
        @(negedge clk);
        move_req = 1'b0;
        repeat (3) wait_step(10, got, cyc);
        @(negedge clk);
        total++;
        if (phase !== 3'd3 || position !== 16'd3 || busy !== 1'b0) begin
            bad++; $display("FAIL mode_setup got ph=%0d pos=%0d busy=%b want 3 3 0", phase, position, busy);
        end
        sb.push_back('{ph: 3'd4, pos: 16'd4, last: 1'b0});
        sb.push_back('{ph: 3'd6, pos: 16'd5, last: 1'b1});
        mode = 2'b00; move_steps = 16'd2; move_req = 1'b1; run = 1'b1;
        @(negedge clk);
        move_req = 1'b0; run = 1'b0;
        total++;
        if (move_ack !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL mode_move_priority got ack=%b busy=%b want 1 1", move_ack, busy);
        end
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            wait_step(10, got, cyc);
            total++;
            if (!got) begin bad++; $display("FAIL mode_timeout want ph=%0d", e.ph); end
            else if (phase !== e.ph || position !== e.pos || done !== e.last || coils !== ~tbl[e.ph]) begin
                bad++; $display("FAIL mode_step got ph=%0d pos=%0d done=%b coils=%b want ph=%0d pos=%0d done=%b",
                                phase, position, done, coils, e.ph, e.pos, e.last);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_half_free();
        test_full_move();
        test_zero_move();
        test_abort();
        test_mode_switch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stepper_sequencer.md
# stepper_sequencer

Parametrised four-coil stepper-motor phase sequencer with programmable step rate, wave/full/half-step modes, direction control, free-run and counted-move operation. It sits between the switch/control logic and the coil driver pins. It exports the current phase and a signed position for the seven-segment display path.

## Interface
- DIV_W, 24, width of the step-period divider
- POS_W, 16, width of the move-length and position counters
- ACTIVE_LOW, 1, coil polarity; 1 means an energised coil is driven 0
- sys_clk_pin  in  1  system clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  master enable; 0 de-energises the coils and cancels any move
- cw  in  1  direction; 1 means clockwise (phase index increments)
- mode  in  2  00 wave, 01 full, 10 half, 11 reserved (treated as half)
- step_div  in  DIV_W  step period is step_div+1 clocks
- run  in  1  free-run request when no move is active
- move_req  in  1  request a counted move of move_steps steps
- move_steps  in  POS_W  unsigned step count, sampled on accept
- move_ack  out  1  1-cycle pulse when a move is accepted
- busy  out  1  high while a counted move is in progress
- done  out  1  1-cycle pulse when a move completes normally
- aborted  out  1  1-cycle pulse when en drops during a move
- coils  out  4  coil drive [A,B,C,D], after polarity
- phase  out  3  current phase index 0..7
- position  out  POS_W  signed step count, wraps modulo 2^POS_W

## Operation
- Phase table (index, energised coils): 0 A, 1 AB, 2 B, 3 BC, 4 C, 5 CD, 6 D, 7 DA.
- Wave mode uses the even indices. Full mode uses the odd indices. Half mode uses all eight.
- Step update on each tick: the index moves by ±1 in half mode. In wave/full mode it moves by ±2 if its parity already matches the mode, otherwise by ±1 to snap. Arithmetic is modulo 8, so 7→0 when cw and 0→7 when ccw.
- position: +1 per cw step, −1 per ccw step, including snap steps. It wraps silently.
- Coil output is energised = table[phase] while en=1, otherwise 0000. coils = ACTIVE_LOW ? ~energised : energised.
- State IDLE: no stepping.
  - Goes to MOVE if en & move_req. move_ack pulses; remaining is loaded with move_steps; the prescaler is cleared.
  - Otherwise goes to FREE if en & run.
- State FREE: steps on every tick.
  - Goes to IDLE if !run or !en.
  - Goes to MOVE if move_req; this takes priority over run.
- State MOVE: busy=1.
  - Each tick takes one step and decrements remaining; when remaining reaches 0 → done, then IDLE.
  - move_req is ignored in this state; there is no ack.
- move_steps=0: the move is accepted with move_ack, and done pulses on the following cycle with no step.
- en falling in MOVE: aborted pulses, state goes to IDLE, remaining is cleared, phase and position are held, and done is not asserted.
- mode, cw and step_div may change at any time. Each takes effect at the next tick. A step_div change does not restart the current period.

## Timing
- Reset values: state IDLE, phase 0, position 0, coils all off (4'b1111 when ACTIVE_LOW=1), and move_ack, busy, done, aborted all 0. The prescaler is 0.
- The prescaler counts 0..step_div. A tick occurs when count==step_div, and the count returns to 0. The prescaler is held at 0 in IDLE and while en=0.
- Accept happens at edge k: move_ack and busy are high in cycle k+1. The first tick is at k+1+step_div, and phase/coils update one cycle after each tick.
- done, busy falling and the final coil update all appear in the same cycle.
- When a tick and en falling coincide, the step is suppressed and abort wins.
- When move_req and run are both present in IDLE, MOVE is entered.

## Structure
- Package stepper_pkg holds:
  - mode_t enum (WAVE, FULL, HALF, RSVD)
  - state_t enum (IDLE, FREE, MOVE)
  - PHASE_TABLE constant, 8 entries × 4 bits
- Sub-module step_prescaler (parameter DIV_W; inputs clear, step_div; output tick).
- The top level contains the FSM, phase/position registers and output polarity.

## Test plan
- Reset with ACTIVE_LOW=1 → coils=1111, phase=0, position=0, and busy, done and aborted all 0.
- en=1, mode=10, cw=1, step_div=3, run=1 → phase steps 0→1→…→7→0, one step every 4 clocks. After 9 steps, position=9 and coils follow the table inverted.
- mode=01, cw=0, starting at phase 0 with a move of 3 steps → phase goes 7, 5, 3, position=−3, and done pulses with the last coil update.
- Move of 0 steps → move_ack, then done on the next cycle, with phase unchanged.
- Move of 10 steps with step_div=1; drop en after 4 steps → aborted pulses, position=4, coils=1111, no done. A new move_req is then ignored until en=1.
- Switch mode 10→00 while at phase 3, cw=1 → next phase 4, then 6. Also assert move_req and run together in IDLE → MOVE is entered.
